// File: rtl/cpu_sequencer_ws_pkg.sv
// Shared definitions for the wait-state control sequencer: opcodes, the
// sequencer state encoding and the Moore control-word decode.
package cpu_seq_pkg;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_BEQ   = 4'd5;
    localparam logic [3:0] OP_BNE   = 4'd6;
    localparam logic [3:0] OP_JMP   = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd8;

    typedef enum logic [3:0] {
        FETCH0 = 4'd0,
        FMEM   = 4'd1,
        FETCH2 = 4'd2,
        DECODE = 4'd3,
        EADDR  = 4'd4,
        RMEM   = 4'd5,
        EXEC   = 4'd6,
        STORE1 = 4'd7,
        WMEM   = 4'd8,
        BRANCH = 4'd9,
        HALT   = 4'd10
    } state_t;

    typedef struct packed {
        logic acc_bus;
        logic load_acc;
        logic pc_bus;
        logic load_pc;
        logic load_ir;
        logic load_mar;
        logic mdr_bus;
        logic load_mdr;
        logic alu_acc;
        logic alu_add;
        logic alu_sub;
        logic alu_xor;
        logic inc_pc;
        logic addr_bus;
        logic cs;
        logic r_nw;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{r_nw: 1'b1, default: 1'b0};

    function automatic logic is_mem_state(input state_t s);
        return (s == FMEM) || (s == RMEM) || (s == WMEM);
    endfunction

    // Opcode-independent part of the control word for each state
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            FETCH0: begin
                c.pc_bus   = 1'b1;
                c.load_mar = 1'b1;
                c.inc_pc   = 1'b1;
                c.load_pc  = 1'b1;
            end
            FMEM, RMEM: c.cs = 1'b1;
            FETCH2: begin
                c.mdr_bus = 1'b1;
                c.load_ir = 1'b1;
            end
            EADDR: begin
                c.addr_bus = 1'b1;
                c.load_mar = 1'b1;
            end
            EXEC: begin
                c.mdr_bus  = 1'b1;
                c.load_acc = 1'b1;
            end
            STORE1: begin
                c.acc_bus  = 1'b1;
                c.load_mdr = 1'b1;
            end
            WMEM: begin
                c.cs      = 1'b1;
                c.r_nw    = 1'b0;
                c.mdr_bus = 1'b1;
            end
            BRANCH: begin
                c.addr_bus = 1'b1;
                c.load_pc  = 1'b1;
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_sequencer_ws_if.sv
// Control/status bundle between the sequencer (master) and the sysbus
// datapath (slave); signal names match the legacy CPU control lines.
interface cpu_sequencer_ws_if #(
    parameter int OP_W = 4
);
    logic [OP_W-1:0] op;
    logic            z_flag;
    logic            mem_ready;

    logic ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR;
    logic ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW;
    logic halted, illegal_op, bus_error;

    modport master (
        input  op, z_flag, mem_ready,
        output ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR,
        output ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW,
        output halted, illegal_op, bus_error
    );

    modport slave (
        output op, z_flag, mem_ready,
        input  ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR,
        input  ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW,
        input  halted, illegal_op, bus_error
    );
endinterface

// File: rtl/cpu_sequencer_ws_wait_timer.sv
// Per-access wait-state counter: counts not-ready cycles of one memory access
// and flags the cycle on which the access has exceeded WAIT_MAX.
module seq_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in_mem,
    input  logic i_ready,
    output logic o_timeout
);
    localparam int             CNT_W     = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] r_cnt;

    // Held at zero outside memory states so every access starts from zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= CNT_ZERO;
        end else if (!i_in_mem) begin
            r_cnt <= CNT_ZERO;
        end else if (!i_ready && (r_cnt != CNT_SAT)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    generate
        if (WAIT_MAX > 0) begin : g_timeout
            // A ready cycle always completes the access, even at the limit
            assign o_timeout = i_in_mem && !i_ready && (r_cnt == CNT_LIMIT);
        end else begin : g_no_timeout
            assign o_timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cpu_sequencer_ws.sv
// Sysbus control sequencer with 4-bit opcode space, mem_ready wait states,
// wait-state timeout (sticky bus_error) and illegal-opcode reporting.
module cpu_sequencer_ws
    import cpu_seq_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int OP_W     = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic               clock,
    input  logic               n_reset,
    cpu_sequencer_ws_if.master bus
);
    generate
        if (OP_W < 4 || WORD_W < 1) begin : g_bad_params
            $error("cpu_sequencer_ws: OP_W must be >= 4 and WORD_W >= 1");
        end
    endgenerate

    state_t r_state;
    state_t w_state_nxt;
    logic   r_bus_error;
    logic   w_in_mem;
    logic   w_timeout;
    logic   w_op_illegal;
    logic   w_take_branch;
    logic   w_branch_op;
    ctrl_t  w_ctrl_raw;
    ctrl_t  w_ctrl;

    assign w_in_mem      = is_mem_state(r_state);
    assign w_op_illegal  = (bus.op > OP_W'(OP_HALT));
    assign w_branch_op   = (bus.op == OP_W'(OP_BEQ)) || (bus.op == OP_W'(OP_BNE));
    assign w_take_branch = (bus.op == OP_W'(OP_JMP))
                         || ((bus.op == OP_W'(OP_BEQ)) && bus.z_flag)
                         || ((bus.op == OP_W'(OP_BNE)) && !bus.z_flag);

    seq_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .i_clk     (clock),
        .i_rst_n   (n_reset),
        .i_in_mem  (w_in_mem),
        .i_ready   (bus.mem_ready),
        .o_timeout (w_timeout)
    );

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH0: w_state_nxt = FMEM;
            FMEM: begin
                if (w_timeout)          w_state_nxt = HALT;
                else if (bus.mem_ready) w_state_nxt = FETCH2;
                else                    w_state_nxt = FMEM;
            end
            FETCH2: w_state_nxt = DECODE;
            DECODE: begin
                if (w_op_illegal)                   w_state_nxt = FETCH0;
                else if (bus.op == OP_W'(OP_HALT))  w_state_nxt = HALT;
                else if (w_take_branch)             w_state_nxt = BRANCH;
                else if (w_branch_op)               w_state_nxt = FETCH0;
                else                                w_state_nxt = EADDR;
            end
            EADDR: begin
                if (bus.op == OP_W'(OP_STORE)) w_state_nxt = STORE1;
                else                           w_state_nxt = RMEM;
            end
            RMEM: begin
                if (w_timeout)          w_state_nxt = HALT;
                else if (bus.mem_ready) w_state_nxt = EXEC;
                else                    w_state_nxt = RMEM;
            end
            EXEC:   w_state_nxt = FETCH0;
            STORE1: w_state_nxt = WMEM;
            WMEM: begin
                if (w_timeout)          w_state_nxt = HALT;
                else if (bus.mem_ready) w_state_nxt = FETCH0;
                else                    w_state_nxt = WMEM;
            end
            BRANCH: w_state_nxt = FETCH0;
            HALT:   w_state_nxt = HALT;
            default: w_state_nxt = FETCH0;
        endcase
    end

    // State register and sticky bus error
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= FETCH0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_error <= r_bus_error | w_timeout;
        end
    end

    // Moore control word, plus ALU select in EXEC and ready-qualified MDR load
    always_comb begin
        w_ctrl_raw          = state_ctrl(r_state);
        w_ctrl_raw.alu_acc  = (r_state == EXEC) && (bus.op == OP_W'(OP_LOAD));
        w_ctrl_raw.alu_add  = (r_state == EXEC) && (bus.op == OP_W'(OP_ADD));
        w_ctrl_raw.alu_sub  = (r_state == EXEC) && (bus.op == OP_W'(OP_SUB));
        w_ctrl_raw.alu_xor  = (r_state == EXEC) && (bus.op == OP_W'(OP_XOR));
        w_ctrl_raw.load_mdr = w_ctrl_raw.load_mdr
                            | (((r_state == FMEM) || (r_state == RMEM)) && bus.mem_ready);
    end

    // Controls stay idle while reset is held, even though the state is FETCH0
    assign w_ctrl = n_reset ? w_ctrl_raw : CTRL_IDLE;

    assign bus.ACC_bus    = w_ctrl.acc_bus;
    assign bus.load_ACC   = w_ctrl.load_acc;
    assign bus.PC_bus     = w_ctrl.pc_bus;
    assign bus.load_PC    = w_ctrl.load_pc;
    assign bus.load_IR    = w_ctrl.load_ir;
    assign bus.load_MAR   = w_ctrl.load_mar;
    assign bus.MDR_bus    = w_ctrl.mdr_bus;
    assign bus.load_MDR   = w_ctrl.load_mdr;
    assign bus.ALU_ACC    = w_ctrl.alu_acc;
    assign bus.ALU_add    = w_ctrl.alu_add;
    assign bus.ALU_sub    = w_ctrl.alu_sub;
    assign bus.ALU_xor    = w_ctrl.alu_xor;
    assign bus.INC_PC     = w_ctrl.inc_pc;
    assign bus.Addr_bus   = w_ctrl.addr_bus;
    assign bus.CS         = w_ctrl.cs;
    assign bus.R_NW       = w_ctrl.r_nw;
    assign bus.halted     = (r_state == HALT);
    assign bus.illegal_op = (r_state == DECODE) && w_op_illegal;
    assign bus.bus_error  = r_bus_error;

endmodule

// File: tb/tb_cpu_sequencer_ws.sv
// Self-checking bench: each instruction is expanded into its expected
// per-cycle control pattern from the instruction-level timing rules.
module tb_cpu_sequencer_ws;
    localparam int WAIT_MAX = 15;

    localparam logic [15:0] C_ACC_BUS  = 16'h8000;
    localparam logic [15:0] C_LD_ACC   = 16'h4000;
    localparam logic [15:0] C_PC_BUS   = 16'h2000;
    localparam logic [15:0] C_LD_PC    = 16'h1000;
    localparam logic [15:0] C_LD_IR    = 16'h0800;
    localparam logic [15:0] C_LD_MAR   = 16'h0400;
    localparam logic [15:0] C_MDR_BUS  = 16'h0200;
    localparam logic [15:0] C_LD_MDR   = 16'h0100;
    localparam logic [15:0] C_ALU_ACC  = 16'h0080;
    localparam logic [15:0] C_ALU_ADD  = 16'h0040;
    localparam logic [15:0] C_ALU_SUB  = 16'h0020;
    localparam logic [15:0] C_ALU_XOR  = 16'h0010;
    localparam logic [15:0] C_INC_PC   = 16'h0008;
    localparam logic [15:0] C_ADDR_BUS = 16'h0004;
    localparam logic [15:0] C_CS       = 16'h0002;
    localparam logic [15:0] C_RNW      = 16'h0001;

    typedef struct {
        logic [3:0]  op;
        logic        z;
        logic        ready;
        logic [18:0] exp;
    } ent_t;

    logic clock;
    logic n_reset;
    int   n_cmp;
    int   n_fail;
    logic [3:0] b_op;
    logic       b_z;
    logic       m_bus_err;
    logic       dummy;
    ent_t exp_q[$];

    cpu_sequencer_ws_if #(.OP_W(4)) bus_if ();

    cpu_sequencer_ws #(
        .WORD_W   (8),
        .OP_W     (4),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .bus     (bus_if.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [18:0] sample();
        return {bus_if.ACC_bus, bus_if.load_ACC, bus_if.PC_bus, bus_if.load_PC,
                bus_if.load_IR, bus_if.load_MAR, bus_if.MDR_bus, bus_if.load_MDR,
                bus_if.ALU_ACC, bus_if.ALU_add, bus_if.ALU_sub, bus_if.ALU_xor,
                bus_if.INC_PC, bus_if.Addr_bus, bus_if.CS, bus_if.R_NW,
                bus_if.halted, bus_if.illegal_op, bus_if.bus_error};
    endfunction

    task automatic push(input logic [15:0] c, input logic h, input logic il, input logic rdy);
        exp_q.push_back('{op: b_op, z: b_z, ready: rdy, exp: {c, h, il, m_bus_err}});
    endtask

    task automatic push_any(input logic [15:0] c, input logic h, input logic il);
        push(c, h, il, 1'($urandom_range(0, 1)));
    endtask

    task automatic mem_access(input logic [15:0] base, input logic rd, input int waits,
                              output logic aborted);
        int nr;
        nr = (waits > WAIT_MAX) ? WAIT_MAX + 1 : waits;
        for (int i = 0; i < nr; i++) push(base, 1'b0, 1'b0, 1'b0);
        if (waits > WAIT_MAX) begin
            m_bus_err = 1'b1;
            for (int i = 0; i < 3; i++) push_any(C_RNW, 1'b1, 1'b0);
            aborted = 1'b1;
        end else begin
            push(base | (rd ? C_LD_MDR : 16'h0000), 1'b0, 1'b0, 1'b1);
            aborted = 1'b0;
        end
    endtask

    // Expected cycle-by-cycle behaviour of one instruction
    task automatic build_instr(input logic [3:0] op, input logic z, input int fw,
                               input int ew, output logic stopped);
        logic ab;
        b_op = op;
        b_z  = z;
        stopped = 1'b0;
        push_any(C_PC_BUS | C_LD_MAR | C_INC_PC | C_LD_PC | C_RNW, 1'b0, 1'b0);
        mem_access(C_CS | C_RNW, 1'b1, fw, ab);
        if (ab) begin
            stopped = 1'b1;
            return;
        end
        push_any(C_MDR_BUS | C_LD_IR | C_RNW, 1'b0, 1'b0);
        push_any(C_RNW, 1'b0, (op > 4'd8));
        if (op > 4'd8) begin
            stopped = 1'b0;
        end else if (op == 4'd8) begin
            for (int i = 0; i < 6; i++) push_any(C_RNW, 1'b1, 1'b0);
            stopped = 1'b1;
        end else if (op == 4'd7 || (op == 4'd5 && z) || (op == 4'd6 && !z)) begin
            push_any(C_ADDR_BUS | C_LD_PC | C_RNW, 1'b0, 1'b0);
        end else if (op == 4'd5 || op == 4'd6) begin
            stopped = 1'b0;
        end else if (op == 4'd1) begin
            push_any(C_ADDR_BUS | C_LD_MAR | C_RNW, 1'b0, 1'b0);
            push_any(C_ACC_BUS | C_LD_MDR | C_RNW, 1'b0, 1'b0);
            mem_access(C_CS | C_MDR_BUS, 1'b0, ew, ab);
            stopped = ab;
        end else begin
            push_any(C_ADDR_BUS | C_LD_MAR | C_RNW, 1'b0, 1'b0);
            mem_access(C_CS | C_RNW, 1'b1, ew, ab);
            stopped = ab;
            if (!ab) begin
                case (op)
                    4'd0:    push_any(C_MDR_BUS | C_LD_ACC | C_RNW | C_ALU_ACC, 1'b0, 1'b0);
                    4'd2:    push_any(C_MDR_BUS | C_LD_ACC | C_RNW | C_ALU_ADD, 1'b0, 1'b0);
                    4'd3:    push_any(C_MDR_BUS | C_LD_ACC | C_RNW | C_ALU_SUB, 1'b0, 1'b0);
                    default: push_any(C_MDR_BUS | C_LD_ACC | C_RNW | C_ALU_XOR, 1'b0, 1'b0);
                endcase
            end
        end
    endtask

    // Called at posedge+1; drives one cycle, samples at posedge+2
    task automatic step(input ent_t e, output logic [18:0] obs);
        bus_if.op        = e.op;
        bus_if.z_flag    = e.z;
        bus_if.mem_ready = e.ready;
        #1;
        obs = sample();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        bus_if.mem_ready = 1'b0;
        n_reset = 1'b0;
        @(posedge clock);
        #1;
        n_reset   = 1'b1;
        m_bus_err = 1'b0;
    endtask

    task automatic test_reset();
        ent_t e;
        logic [18:0] obs;
        bus_if.op = 4'd0;
        bus_if.z_flag = 1'b0;
        bus_if.mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        obs = sample();
        n_cmp++;
        if (obs !== {C_RNW, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_idle: got %h, expected %h", obs, {C_RNW, 3'b000});
        end
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        m_bus_err = 1'b0;
        build_instr(4'd0, 1'b0, 0, 6, dummy);
        for (int k = 0; k < 7; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL reset_pre[%0d]: got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
        exp_q.delete();
        bus_if.mem_ready = 1'b0;
        n_reset = 1'b0;
        #1;
        obs = sample();
        n_cmp++;
        if (obs !== {C_RNW, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid_rmem: got %h, expected %h", obs, {C_RNW, 3'b000});
        end
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        build_instr(4'd6, 1'b1, 0, 0, dummy);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL reset_post[%0d]: got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
    endtask

    task automatic test_add_zero_wait();
        ent_t e;
        logic [18:0] obs;
        build_instr(4'd2, 1'b0, 0, 0, dummy);
        build_instr(4'd0, 1'b1, 0, 0, dummy);
        build_instr(4'd3, 1'b0, 0, 0, dummy);
        build_instr(4'd4, 1'b1, 0, 0, dummy);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL add_zero_wait[%0d]: got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
    endtask

    task automatic test_load_waits();
        ent_t e;
        logic [18:0] obs;
        build_instr(4'd0, 1'b0, 0, 3, dummy);
        build_instr(4'd1, 1'b0, 2, 1, dummy);
        build_instr(4'd1, 1'b1, 0, 0, dummy);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL load_waits[%0d]: got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
    endtask

    task automatic test_branches();
        ent_t e;
        logic [18:0] obs;
        build_instr(4'd5, 1'b1, 0, 0, dummy);
        build_instr(4'd6, 1'b1, 0, 0, dummy);
        build_instr(4'd5, 1'b0, 0, 0, dummy);
        build_instr(4'd6, 1'b0, 0, 0, dummy);
        build_instr(4'd7, 1'b1, 0, 0, dummy);
        build_instr(4'd2, 1'b0, 0, 0, dummy);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL branches[%0d]: got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
    endtask

    task automatic test_illegal_halt();
        ent_t e;
        logic [18:0] obs;
        build_instr(4'hC, 1'b0, 0, 0, dummy);
        build_instr(4'hF, 1'b1, 1, 0, dummy);
        build_instr(4'd2, 1'b0, 0, 0, dummy);
        build_instr(4'd8, 1'b0, 0, 0, dummy);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL illegal_halt[%0d]: got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
        apply_reset();
    endtask

    task automatic test_timeout();
        ent_t e;
        logic [18:0] obs;
        build_instr(4'd2, 1'b0, 16, 0, dummy);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL timeout_fetch[%0d]: got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
        apply_reset();
        build_instr(4'd2, 1'b0, 15, 0, dummy);
        build_instr(4'd0, 1'b0, 0, 15, dummy);
        build_instr(4'd1, 1'b0, 0, 20, dummy);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL timeout_limit[%0d]: got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
        apply_reset();
        build_instr(4'd6, 1'b1, 0, 0, dummy);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL timeout_cleared[%0d]: got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
    endtask

    task automatic test_random();
        ent_t e;
        logic [18:0] obs;
        logic [3:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd8) op = 4'd7;
            build_instr(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                        int'($urandom_range(0, 4)), dummy);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(e, obs);
            n_cmp++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL random[%0d]: op=%0d z=%b got ctrl=%h hie=%b, expected ctrl=%h hie=%b",
                         k, e.op, e.z, obs[18:3], obs[2:0], e.exp[18:3], e.exp[2:0]);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        n_reset   = 1'b0;
        m_bus_err = 1'b0;
        b_op      = 4'd0;
        b_z       = 1'b0;
        test_reset();
        test_add_zero_wait();
        test_load_waits();
        test_branches();
        test_illegal_halt();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
